// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helper functions shared by the UART blocks.
// Default line settings are also used by the UART_rx benches so that a
// transmitter and receiver built from the same constants agree on timing.
package uart_pkg;

    localparam int DEFAULT_BIT_RATE = 115200;
    localparam int DEFAULT_CLK_FREQ = 16_000_000;

    // Frame phases of the transmitter; PARITY is only visited when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per line bit, integer-truncated.
    function automatic int calc_clks_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] io_i_data;
    logic                    io_i_valid;
    logic                    io_o_ready;

    modport master (
        output io_i_data,
        output io_i_valid,
        input  io_o_ready
    );

    modport slave (
        input  io_i_data,
        input  io_i_valid,
        output io_o_ready
    );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clock cycles within one line bit and flags the last one.
// The count restarts at zero on every bit so no fractional error accumulates.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 138
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end = enable && !clear && (count_q == LAST_CNT);

    // Next count: hold at zero when cleared, wrap on the final cycle of a bit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = bit_end ? '0 : count_q + CNT_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (start bit, data LSB first, optional even
// parity, STOP_BITS stop bits). Even parity is built in when the macro
// UART_TX_PARITY_EN is defined; otherwise DATA goes straight to STOP.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    uart_tx_if.slave   tx_if,
    output logic       io_o_serial_data,
    output logic       io_o_busy,
    output logic       io_o_tx_done
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int IDX_W        = cnt_width(PAYLOAD_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    uart_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    line_q, line_d;
    logic                    busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic accept;
    logic bit_end;
    logic timer_clear;
    logic timer_enable;

    assign tx_if.io_o_ready = (state_q == IDLE);
    assign accept           = tx_if.io_i_valid && (state_q == IDLE);
    assign timer_clear      = (state_q == IDLE);
    assign timer_enable     = (state_q != IDLE);

    assign io_o_serial_data = line_q;
    assign io_o_busy        = busy_q;
    // Final cycle of the last stop bit, decoded from registered state and count.
    assign io_o_tx_done     = (state_q == STOP) && bit_end && (idx_q == LAST_STOP_IDX);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .bit_end (bit_end)
    );

    // Frame sequencing: next state, bit index, shift register and next line level.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = line_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                idx_d  = '0;
                if (accept) begin
                    shift_d = tx_if.io_i_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.io_i_data;
`endif
                    state_d = START;
                    line_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_DATA_IDX) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        line_d  = parity_q;
`else
                        state_d = STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == LAST_STOP_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                line_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Expected line levels come from
// a frame model: bit k of the frame is start(0), data LSB first, optional even
// parity, then stop(1), each lasting CLK_FREQ/BIT_RATE cycles.
module tb_uart_tx;

    localparam int BIT_RATE = 115200;
    localparam int CLK_FREQ = 16_000_000;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int CPB      = CLK_FREQ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = (1 + PB + PAR + SB) * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic serial;
    logic busy;
    logic tx_done;

    always #5 clock = ~clock;

    uart_tx_if #(.PAYLOAD_BITS(PB)) tx_if ();

    uart_tx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_FREQ     (CLK_FREQ),
        .PAYLOAD_BITS (PB),
        .STOP_BITS    (SB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .tx_if            (tx_if.slave),
        .io_o_serial_data (serial),
        .io_o_busy        (busy),
        .io_o_tx_done     (tx_done)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    // Expected line level during cycle c (1-based) after the accepting edge.
    function automatic logic exp_line(input logic [7:0] w, input int c);
        int k;
        int ones;
        k    = (c - 1) / CPB;
        ones = 0;
        for (int i = 0; i < PB; i++) ones += int'(w[i]);
        if (k == 0) return 1'b0;
        if (k <= PB) return w[k-1];
        if (PAR == 1 && k == PB + 1) return logic'(ones % 2);
        return 1'b1;
    endfunction

    // Offer a word, wait for acceptance, then check every cycle of the frame
    // and the first idle cycle after it. Ends at the negedge of cycle FRAME_LEN+1.
    task automatic send_frame(input logic [7:0] word, input bit hold_next,
                              input logic [7:0] next_word, input bit inject,
                              output longint acc_cyc);
        int wait_n   = 0;
        int line_err = 0;
        int done_err = 0;
        int hs_err   = 0;
        int first_bad = -1;
        logic [7:0] got = '0;
        tx_if.io_i_data  = word;
        tx_if.io_i_valid = 1'b1;
        while (tx_if.io_o_ready !== 1'b1 && wait_n < 4000) begin
            @(negedge clock);
            wait_n++;
        end
        acc_cyc = cyc;
        n_checks++;
        if (wait_n >= 4000) begin
            n_fail++;
            $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", tx_if.io_o_ready, wait_n);
            tx_if.io_i_valid = 1'b0;
            return;
        end
        for (int c = 1; c <= FRAME_LEN; c++) begin
            @(negedge clock);
            if (hold_next) begin
                tx_if.io_i_data  = next_word;
                tx_if.io_i_valid = 1'b1;
            end else begin
                tx_if.io_i_data  = 8'($urandom);
                tx_if.io_i_valid = 1'b0;
                if (inject && c == 3 * CPB + 5) begin
                    tx_if.io_i_data  = 8'h55;
                    tx_if.io_i_valid = 1'b1;
                end
            end
            if (serial !== exp_line(word, c)) begin
                line_err++;
                if (first_bad < 0) first_bad = c;
            end
            if (tx_done !== (c == FRAME_LEN)) done_err++;
            if (busy !== 1'b1 || tx_if.io_o_ready !== 1'b0) hs_err++;
            if ((c - 1) % CPB == CPB / 2) begin
                int k;
                k = (c - 1) / CPB;
                if (k >= 1 && k <= PB) got[k-1] = serial;
            end
        end
        n_checks++;
        if (line_err !== 0) begin
            n_fail++;
            $display("FAIL frame_line word=%h: %0d bad cycles (first at %0d), required 0", word, line_err, first_bad);
        end
        n_checks++;
        if (done_err !== 0) begin
            n_fail++;
            $display("FAIL frame_tx_done word=%h: %0d bad cycles, required pulse only at cycle %0d", word, done_err, FRAME_LEN);
        end
        n_checks++;
        if (hs_err !== 0) begin
            n_fail++;
            $display("FAIL frame_busy_ready word=%h: %0d bad cycles, required busy=1 ready=0", word, hs_err);
        end
        n_checks++;
        if (got !== word) begin
            n_fail++;
            $display("FAIL frame_decode: got %h, required %h", got, word);
        end
        @(negedge clock);
        n_checks++;
        if ({serial, busy, tx_done, tx_if.io_o_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL frame_idle word=%h: line,busy,done,ready=%b, required 1001", word,
                     {serial, busy, tx_done, tx_if.io_o_ready});
        end
        $display("frame word=%h accepted_at=%0d line_err=%0d done_err=%0d decoded=%h", word, acc_cyc, line_err, done_err, got);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_if.io_i_valid = 1'b0;
        tx_if.io_i_data  = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({serial, busy, tx_done, tx_if.io_o_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_state: line,busy,done,ready=%b, required 1001", {serial, busy, tx_done, tx_if.io_o_ready});
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({serial, busy, tx_done, tx_if.io_o_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL post_reset_idle: line,busy,done,ready=%b, required 1001", {serial, busy, tx_done, tx_if.io_o_ready});
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        longint t;
        send_frame(8'h16, 1'b0, 8'h00, 1'b0, t);
    endtask

    task automatic test_back_to_back();
        longint t1, t2;
        send_frame(8'h32, 1'b1, 8'haf, 1'b0, t1);
        send_frame(8'haf, 1'b0, 8'h00, 1'b0, t2);
        n_checks++;
        if (t2 - t1 !== longint'(FRAME_LEN + 1)) begin
            n_fail++;
            $display("FAIL b2b_interval: %0d cycles, required %0d", t2 - t1, FRAME_LEN + 1);
        end
        $display("back_to_back interval=%0d", t2 - t1);
    endtask

    task automatic test_ignore_midframe();
        longint t;
        int errs = 0;
        logic [7:0] w;
        w = 8'($urandom);
        send_frame(w, 1'b0, 8'h00, 1'b1, t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (serial !== 1'b1 || busy !== 1'b0) errs++;
        end
        n_checks++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL ignore_no_extra_frame: %0d active cycles, required 0", errs);
        end
        $display("ignored mid-frame 55 during word=%h, idle_errs=%0d", w, errs);
    endtask

    task automatic test_reset_mid_frame();
        longint t;
        int errs = 0;
        tx_if.io_i_data  = 8'hff;
        tx_if.io_i_valid = 1'b1;
        for (int i = 0; i < 10 && tx_if.io_o_ready !== 1'b1; i++) @(negedge clock);
        for (int c = 1; c <= 500; c++) begin
            @(negedge clock);
            tx_if.io_i_valid = 1'b0;
            if (tx_done !== 1'b0) errs++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({serial, busy, tx_done, tx_if.io_o_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_abort_state: line,busy,done,ready=%b, required 1001", {serial, busy, tx_done, tx_if.io_o_ready});
        end
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if (tx_done !== 1'b0 || serial !== 1'b1) errs++;
        end
        n_checks++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: %0d cycles with done or low line, required 0", errs);
        end
        $display("reset mid-frame of ff, quiet_errs=%0d", errs);
        send_frame(8'h16, 1'b0, 8'h00, 1'b0, t);
    endtask

    task automatic test_reset_with_valid();
        int errs = 0;
        reset = 1'b1;
        tx_if.io_i_data  = 8'h3c;
        tx_if.io_i_valid = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tx_if.io_i_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (serial !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge clock);
        end
        n_checks++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL reset_wins_over_valid: %0d active cycles, required 0", errs);
        end
        $display("reset+valid 3c, active_cycles=%0d", errs);
    endtask

    task automatic test_random();
        logic [7:0] words[6];
        bit prev_hold = 1'b0;
        bit hold;
        longint t;
        for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            if (!prev_hold) begin
                int gap;
                gap = $urandom_range(0, 15);
                for (int g = 0; g < gap; g++) @(negedge clock);
            end
            hold = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(words[i], hold, (i < 5) ? words[i+1] : 8'h00, 1'b0, t);
            prev_hold = hold;
        end
    endtask

    initial begin
        tx_if.io_i_valid = 1'b0;
        tx_if.io_i_data  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_mid_frame();
        test_reset_with_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: the transmit-side counterpart of the existing UART_rx.
- Accepts a PAYLOAD_BITS-wide word over a valid/ready handshake and serialises it as 8N1-style frames: start bit, data LSB-first, optional parity, stop bit(s).
- Uses the same BIT_RATE/CLK_FREQ/PAYLOAD_BITS parameterisation as UART_rx so TX→RX loopback works at matching settings.

Parameters:
- BIT_RATE, 115200, line rate in bit/s.
- CLK_FREQ, 16_000_000, clock frequency in Hz.
- PAYLOAD_BITS, 8, data bits per frame (legal range 5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- io_i_data  input  PAYLOAD_BITS  word to transmit; sampled only on handshake.
- io_i_valid  input  1  producer has a word.
- io_o_ready  output  1  high iff FSM in IDLE; handshake = valid & ready.
- io_o_serial_data  output  1  TX line, idle high; registered.
- io_o_busy  output  1  high from the cycle after acceptance through the end of the last stop bit.
- io_o_tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- One clock domain, named `clock`. Reset is synchronous and active-high, named `reset`.
- CLKS_PER_BIT = CLK_FREQ / BIT_RATE, integer-truncated; 138 at defaults.
- Bit counter width = clog2(CLKS_PER_BIT). Index counter width = clog2(PAYLOAD_BITS).
- Reset values (the cycle after reset is sampled high):
  - state IDLE; io_o_serial_data = 1; io_o_busy = 0; io_o_tx_done = 0; io_o_ready = 1.
  - Counters = 0; shift register = 0.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: line = 1.
  - On valid & ready: latch io_i_data into the shift register and go to START.
  - Line goes 0 on the next clock edge, so acceptance-to-line-low latency = 1 cycle.
- START: line = 0 for exactly CLKS_PER_BIT cycles.
- DATA: shift out bit[0] first; each bit held CLKS_PER_BIT cycles; leave after PAYLOAD_BITS bits.
- PARITY: only present with the optional feature; held CLKS_PER_BIT cycles.
- STOP: line = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - io_o_tx_done = 1 on the last cycle; next state IDLE.
- Frame length = (1 + PAYLOAD_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
  - Default: 10*138 = 1380 cycles.
- Back-to-back operation:
  - The earliest next acceptance is the first IDLE cycle after tx_done.
  - The line stays high during that cycle, so the minimum acceptance-to-acceptance interval is frame length + 1 cycles.
- Valid while not ready: ignored. io_i_data is not sampled and no queueing occurs. The producer must hold valid.
- io_i_data changing mid-frame has no effect; the latched copy is used.
- Reset mid-frame: aborts immediately.
  - Next cycle: line = 1, IDLE, ready = 1.
  - No tx_done pulse for the aborted frame.
- Reset and valid asserted in the same cycle: reset wins; the word is not accepted.
- Counter wrap: the bit counter runs 0..CLKS_PER_BIT-1, then resets to 0 and advances the bit. No drift accumulates across bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - Transmitted bit = XOR of the latched payload (even parity).
  - Frame grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - CLKS_PER_BIT computation function.
  - Default BIT_RATE/CLK_FREQ constants, reused by UART_rx benches.
- One natural sub-module, uart_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clock, reset, clear, enable.
  - Output: bit_end pulse on count == CLKS_PER_BIT-1.
  - The FSM advances only on bit_end.

Test Plan:
- Send 8'h16 after reset → line low within 1 cycle of handshake; bits 0,1,1,0,1,0,0,0 at 138-cycle spacing, then stop = 1; tx_done pulses at cycle 1380; UART_rx in loopback reports io_o_data = 8'h16 with io_o_rx_done.
- Back-to-back 8'h32 then 8'haf with valid held high → second handshake exactly 1381 cycles after the first; loopback receives 8'h32 then 8'haf; ready is low throughout each frame.
- Pulse valid with 8'h55 mid-frame (during DATA) → ignored; line waveform of the current frame unchanged; no extra frame afterwards.
- Assert reset for 1 cycle at cycle 500 of a frame carrying 8'hff → next cycle line = 1, busy = 0, ready = 1; no tx_done; a new 8'h16 frame afterwards is correct.
- With UART_TX_PARITY_EN defined: send 8'h16 → parity bit = 1, frame = 1518 cycles; send 8'haf → parity bit = 0.
- Reset and valid in the same cycle with 8'h3c → no frame starts; line stays 1 for ≥ 2000 cycles.
